// File: rtl/combine_pipe_pkg.sv
// combine_pipe_pkg
// Shared definitions for the combine_pipe capture-and-combine pipeline:
//   mode_t          - reduction operator carried with every input beat
//   *_MIN / *_MAX   - legal parameter ranges checked at elaboration
package combine_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_AND  = 2'd0,
        MODE_OR   = 2'd1,
        MODE_XOR  = 2'd2,
        MODE_PASS = 2'd3
    } mode_t;

    localparam int NCH_MIN    = 2;
    localparam int NCH_MAX    = 16;
    localparam int W_MIN      = 1;
    localparam int W_MAX      = 64;
    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 8;
    localparam int CW_MIN     = 1;
    localparam int CW_MAX     = 64;

endpackage

// File: rtl/combine_pipe_if.sv
// combine_pipe_if
// Valid/ready stream bundle for combine_pipe.
//   in_valid / in_ready    - input handshake
//   in_data [NCH*W]        - channel c in bits [c*W +: W]
//   in_mode                - reduction operator, travels with the beat
//   out_valid / out_ready  - output handshake
//   out_data [W]           - reduced result
// Modports: master = stream producer/consumer side (testbench or parent),
//           slave  = the pipeline itself.
interface combine_pipe_if
    import combine_pipe_pkg::*;
#(
    parameter int NCH = 2,
    parameter int W   = 1
) ();

    logic             in_valid;
    logic             in_ready;
    logic [NCH*W-1:0] in_data;
    mode_t            in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/combine_pipe_reduce.sv
// combine_pipe_reduce
// Purely combinational NCH x W -> W bitwise reducer.
//   data   [NCH*W] - channel c in bits [c*W +: W]
//   mode           - AND / OR / XOR across all channels, or pass channel 0
//   result [W]     - reduced value, no carries or extension
module combine_pipe_reduce
    import combine_pipe_pkg::*;
#(
    parameter int NCH = 2,
    parameter int W   = 1
) (
    input  logic [NCH*W-1:0] data,
    input  mode_t            mode,
    output logic [W-1:0]     result
);

    logic [W-1:0] and_acc;
    logic [W-1:0] or_acc;
    logic [W-1:0] xor_acc;

    always_comb begin
        and_acc = data[W-1:0];
        or_acc  = data[W-1:0];
        xor_acc = data[W-1:0];
        for (int c = 1; c < NCH; c++) begin
            and_acc = and_acc & data[c*W +: W];
            or_acc  = or_acc  | data[c*W +: W];
            xor_acc = xor_acc ^ data[c*W +: W];
        end

        result = data[W-1:0];
        case (mode)
            MODE_AND:  result = and_acc;
            MODE_OR:   result = or_acc;
            MODE_XOR:  result = xor_acc;
            MODE_PASS: result = data[W-1:0];
            default:   result = data[W-1:0];
        endcase
    end

endmodule

// File: rtl/combine_pipe.sv
// combine_pipe
// Elastic multi-channel capture-and-combine pipeline with valid/ready flow
// control. Stage 0 captures raw channels + mode, stage 1 holds the reduced
// W-bit result, stages 2..STAGES-1 are plain delay registers. Each stage
// has its own valid bit, so bubbles are squeezed out and the pipeline
// holds up to STAGES beats under backpressure.
//   clk1      - clock, all state changes on rising edge
//   rst       - asynchronous active-high reset
//   bus       - combine_pipe_if.slave stream (input beats in, results out)
//   evt_cnt   - saturating count of nonzero results delivered
//               (only when COMBINE_PIPE_CNT_EN is defined)
// Optional feature macro: COMBINE_PIPE_CNT_EN
module combine_pipe
    import combine_pipe_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int W      = 1,
    parameter int STAGES = 3,
    parameter int CW     = 16
) (
    input  logic              clk1,
    input  logic              rst,
    combine_pipe_if.slave     bus
`ifdef COMBINE_PIPE_CNT_EN
    ,
    output logic [CW-1:0]     evt_cnt
`endif
);

    if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
        $error("combine_pipe: NCH out of range");
    end
    if (W < W_MIN || W > W_MAX) begin : g_bad_w
        $error("combine_pipe: W out of range");
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("combine_pipe: STAGES out of range");
    end
    if (CW < CW_MIN || CW > CW_MAX) begin : g_bad_cw
        $error("combine_pipe: CW out of range");
    end

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] vld;
    logic [NCH*W-1:0]  cap_data;
    mode_t             cap_mode;
    logic [W-1:0]      red_result;
    logic [W-1:0]      stage_data [1:STAGES-1];

    combine_pipe_reduce #(
        .NCH (NCH),
        .W   (W)
    ) u_reduce (
        .data   (cap_data),
        .mode   (cap_mode),
        .result (red_result)
    );

    // Ready ripples backwards from the output: a stage can take new data
    // if it is empty or its own contents are moving on this cycle.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld[k] || rdy[k+1];
        end
    end

    // Valid bits follow the upstream valid whenever a stage loads; data
    // registers only load with a real beat, so an emptied output keeps
    // presenting its last delivered value.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            vld      <= '0;
            cap_data <= '0;
            cap_mode <= MODE_AND;
            for (int k = 1; k < STAGES; k++) begin
                stage_data[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                vld[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    cap_data <= bus.in_data;
                    cap_mode <= bus.in_mode;
                end
            end
            if (rdy[1]) begin
                vld[1] <= vld[0];
                if (vld[0]) begin
                    stage_data[1] <= red_result;
                end
            end
            for (int k = 2; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        stage_data[k] <= stage_data[k-1];
                    end
                end
            end
        end
    end

    // Reset must also block acceptance, since empty stages look ready.
    assign bus.in_ready  = rdy[0] && !rst;
    assign bus.out_valid = vld[STAGES-1];
    assign bus.out_data  = stage_data[STAGES-1];

`ifdef COMBINE_PIPE_CNT_EN
    // Counts delivered nonzero results and sticks at all-ones.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            evt_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready && (bus.out_data != '0)
                     && (evt_cnt != {CW{1'b1}})) begin
            evt_cnt <= evt_cnt + CW'(1);
        end
    end
`endif

endmodule
